// File: rtl/traffic_display_scan.sv
// ---------------------------------------------------------------------------
// traffic_display_scan
// Display stage of the traffic light controller. It takes the four BCD
// countdown digits and the two light flags. It drives a 4-digit multiplexed
// common-cathode 7-segment display and the red/green lamp LEDs of each road.
//
// The four digits are captured once per scan frame, at the last cycle of
// digit 3. A countdown update that arrives mid-frame therefore cannot tear the
// displayed value. Code 4'hF is blank and shows dark. Codes 4'hA..4'hE show a
// dash (segment g only).
//
// Optional feature (compile-time macro): LEADING_ZERO_BLANK_EN
//   When defined, a tens digit (A_Time_H / B_Time_H) whose captured value is 0
//   is shown dark. Units digits are never blanked.
//
// Parameters
//   SCAN_DIV  CLK cycles each digit is held (>= 1); one frame = 4*SCAN_DIV
//
// Ports
//   CLK       in   system clock, rising edge
//   R         in   asynchronous reset, active-high
//   A_Time_H  in   [3:0] road A tens digit  (0-9, 4'hF = blank)
//   A_Time_L  in   [3:0] road A units digit
//   B_Time_H  in   [3:0] road B tens digit
//   B_Time_L  in   [3:0] road B units digit
//   A_Light   in   1 = road A green, 0 = road A red
//   B_Light   in   1 = road B green, 0 = road B red
//   SEG       out  [6:0] segments {g,f,e,d,c,b,a}, active-high, registered
//   DIG       out  [3:0] one-hot digit select; bit0=A_H bit1=A_L bit2=B_H bit3=B_L
//   LED_A_G / LED_A_R / LED_B_G / LED_B_R  out  registered lamp drives
// ---------------------------------------------------------------------------
module traffic_display_scan #(
    parameter int SCAN_DIV = 4
) (
    input  logic       CLK,
    input  logic       R,
    input  logic [3:0] A_Time_H,
    input  logic [3:0] A_Time_L,
    input  logic [3:0] B_Time_H,
    input  logic [3:0] B_Time_L,
    input  logic       A_Light,
    input  logic       B_Light,
    output logic [6:0] SEG,
    output logic [3:0] DIG,
    output logic       LED_A_G,
    output logic       LED_A_R,
    output logic       LED_B_G,
    output logic       LED_B_R
);

    localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    // BCD to 7-segment, {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA, 4'hB, 4'hC, 4'hD, 4'hE:
                     seg = 7'h40;
            4'hF:    seg = 7'h00;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    // Digit index to one-hot select; never multi-hot
    function automatic logic [3:0] onehot4(input logic [1:0] i);
        logic [3:0] oh;
        case (i)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    logic [DIV_W-1:0] div_cnt_r;
    logic [1:0]       idx_r;
    logic [3:0][3:0]  snap_r;       // [0]=A_H [1]=A_L [2]=B_H [3]=B_L
    logic             wrap_s;
    logic             frame_end_s;
    logic [3:0]       cur_code_s;
    logic [6:0]       seg_next_s;

    assign wrap_s      = (div_cnt_r == DIV_LAST);
    assign frame_end_s = wrap_s && (idx_r == 2'd3);
    assign cur_code_s  = snap_r[idx_r];

    // Segment pattern for the digit currently selected
    always_comb begin
        seg_next_s = seg_decode(cur_code_s);
`ifdef LEADING_ZERO_BLANK_EN
        // idx_r[0]==0 selects a tens digit (idx 0 or 2)
        if (!idx_r[0] && (cur_code_s == 4'h0)) begin
            seg_next_s = 7'h00;
        end else begin
            seg_next_s = seg_decode(cur_code_s);
        end
`endif
    end

    // Prescaler and digit index
    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            div_cnt_r <= '0;
            idx_r     <= 2'd0;
        end else if (wrap_s) begin
            div_cnt_r <= '0;
            idx_r     <= idx_r + 2'd1;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
        end
    end

    // Frame snapshot: all four digits load together at the end of a frame
    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            snap_r <= {4{4'hF}};
        end else if (frame_end_s) begin
            snap_r <= {B_Time_L, B_Time_H, A_Time_L, A_Time_H};
        end
    end

    // Registered display outputs, built from pre-edge index and snapshot
    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            SEG <= 7'h00;
            DIG <= 4'b0000;
        end else begin
            SEG <= seg_next_s;
            DIG <= onehot4(idx_r);
        end
    end

    // Registered lamp drives; blink toggling passes straight through
    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            LED_A_G <= 1'b0;
            LED_A_R <= 1'b0;
            LED_B_G <= 1'b0;
            LED_B_R <= 1'b0;
        end else begin
            LED_A_G <= A_Light;
            LED_A_R <= ~A_Light;
            LED_B_G <= B_Light;
            LED_B_R <= ~B_Light;
        end
    end

endmodule

// File: tb/tb_traffic_display_scan.sv
// Scoreboard bench for traffic_display_scan. A reference model counts cycles
// since reset. On every rising edge it pushes the expected outputs into a
// queue. A monitor pops that queue on each falling edge and compares.
module tb_traffic_display_scan;

    localparam int SCAN_DIV = 4;
    localparam int FRAME    = 4 * SCAN_DIV;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h00
    };

    logic       CLK;
    logic       R;
    logic [3:0] A_Time_H, A_Time_L, B_Time_H, B_Time_L;
    logic       A_Light, B_Light;
    logic [6:0] SEG;
    logic [3:0] DIG;
    logic       LED_A_G, LED_A_R, LED_B_G, LED_B_R;

    int n_checks = 0;
    int n_fail   = 0;

    traffic_display_scan #(.SCAN_DIV(SCAN_DIV)) dut (
        .CLK      (CLK),
        .R        (R),
        .A_Time_H (A_Time_H),
        .A_Time_L (A_Time_L),
        .B_Time_H (B_Time_H),
        .B_Time_L (B_Time_L),
        .A_Light  (A_Light),
        .B_Light  (B_Light),
        .SEG      (SEG),
        .DIG      (DIG),
        .LED_A_G  (LED_A_G),
        .LED_A_R  (LED_A_R),
        .LED_B_G  (LED_B_G),
        .LED_B_R  (LED_B_R)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // {SEG, DIG, LED_A_G, LED_A_R, LED_B_G, LED_B_R}
    function automatic logic [14:0] pack_out();
        return {SEG, DIG, LED_A_G, LED_A_R, LED_B_G, LED_B_R};
    endfunction

    task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got SEG=%h DIG=%b LED=%b, want SEG=%h DIG=%b LED=%b",
                     name, $time, act[14:8], act[7:4], act[3:0], exp[14:8], exp[7:4], exp[3:0]);
        end
    endtask

    // Reference model. m_cyc counts edges since reset release. Each digit is
    // shown for SCAN_DIV cycles, so the digit shown is (m_cyc / SCAN_DIV) % 4.
    // The snapshot refreshes on the last cycle of each frame.
    logic [3:0]  m_snap [4];
    int          m_cyc;
    int          m_k;
    logic [3:0]  m_code;
    logic [6:0]  m_seg;
    logic [3:0]  m_dig;
    logic [14:0] exp_q [$];

    // Model update on each edge; reset flushes pending expectations
    always @(posedge CLK or posedge R) begin
        if (R) begin
            m_cyc = 0;
            for (int i = 0; i < 4; i++) m_snap[i] = 4'hF;
            exp_q.delete();
        end else begin
            m_k    = (m_cyc / SCAN_DIV) % 4;
            m_code = m_snap[m_k];
            m_seg  = SEG_TAB[m_code];
`ifdef LEADING_ZERO_BLANK_EN
            if ((m_k == 0 || m_k == 2) && m_code == 4'h0) m_seg = 7'h00;
`endif
            m_dig = 4'b0000;
            m_dig[m_k] = 1'b1;
            exp_q.push_back({m_seg, m_dig, A_Light, ~A_Light, B_Light, ~B_Light});
            if (m_cyc % FRAME == FRAME - 1) begin
                m_snap[0] = A_Time_H;
                m_snap[1] = A_Time_L;
                m_snap[2] = B_Time_H;
                m_snap[3] = B_Time_L;
            end
            m_cyc++;
        end
    end

    // Monitor: compare DUT outputs against the oldest expectation
    always @(negedge CLK) begin
        if (!R && exp_q.size() > 0) begin
            check("scan", pack_out(), exp_q.pop_front());
        end
    end

    // Advance n edges, then drive inputs 2 time units after the edge
    task automatic run(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic set_digits(input logic [3:0] ah, input logic [3:0] al,
                              input logic [3:0] bh, input logic [3:0] bl);
        A_Time_H = ah; A_Time_L = al; B_Time_H = bh; B_Time_L = bl;
    endtask

    initial begin
        R = 1'b1;
        set_digits(4'd8, 4'd9, 4'd2, 4'd9);
        A_Light = 1'b1;
        B_Light = 1'b0;
        #12;
        check("reset_state", pack_out(), 15'd0);
        #6;
        R = 1'b0;

        // Blank first frame, then 89 / 29; mid-frame units change 9 -> 8
        run(FRAME + 2);
        A_Time_L = 4'd8;
        run(2 * FRAME);

        // Controller blink: all blank, then an invalid tens code
        set_digits(4'hF, 4'hF, 4'hF, 4'hF);
        run(2 * FRAME);
        A_Time_H = 4'hB;
        run(2 * FRAME);

        // Tens digit 0 on road B
        set_digits(4'd1, 4'd7, 4'd0, 4'd5);
        run(2 * FRAME);

        // Lights toggling every cycle
        for (int i = 0; i < 20; i++) begin
            A_Light = ~A_Light;
            B_Light = ~B_Light;
            run(1);
        end

        // Asynchronous reset mid-frame, between edges
        run(7);
        #1;
        R = 1'b1;
        #1;
        check("async_reset", pack_out(), 15'd0);
        @(posedge CLK);
        #1;
        check("reset_hold", pack_out(), 15'd0);
        #3;
        R = 1'b0;
        run(FRAME);

        // Randomized traffic: lights every cycle, occasional digit updates
        for (int i = 0; i < 500; i++) begin
            A_Light = 1'($urandom_range(0, 1));
            B_Light = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0:       A_Time_H = 4'($urandom_range(0, 15));
                    1:       A_Time_L = 4'($urandom_range(0, 15));
                    2:       B_Time_H = 4'($urandom_range(0, 15));
                    default: B_Time_L = 4'($urandom_range(0, 15));
                endcase
            end
            run(1);
        end

        @(negedge CLK);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
